// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer that lets two requesters share one
// single-port synchronous memory; every output is registered.
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_r_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        dbg_state
);

    // Handshake: a requester raises req with we/addr/wdata stable, holds it
    // until its one-cycle ack, and drops it at the edge ending the ack cycle;
    // req still high in the next IDLE cycle is a new request.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        RD     = 3'd2,
        RDWAIT = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state, state_nx;
    logic                last_grant, last_grant_nx;  // 0 = A, 1 = B
    logic                gnt, gnt_nx;
    logic                grant, sel_b, sel_we;
    logic                mem_r_w_nx, a_ack_nx, b_ack_nx;
    logic [ADDR_W-1:0]   mem_addr_nx;
    logic [DATA_W-1:0]   mem_wdata_nx, a_rdata_nx, b_rdata_nx;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Outputs are computed one cycle ahead so they line up with the state.
    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        gnt_nx        = gnt;
        grant         = 1'b0;
        sel_b         = 1'b0;
        sel_we        = 1'b0;
        mem_r_w_nx    = 1'b0;
        mem_addr_nx   = mem_addr;
        mem_wdata_nx  = mem_wdata;
        a_ack_nx      = 1'b0;
        b_ack_nx      = 1'b0;
        a_rdata_nx    = a_rdata;
        b_rdata_nx    = b_rdata;
        case (state)
            IDLE: begin
                if (a_req && b_req) begin
                    grant = 1'b1;
                    sel_b = ~last_grant;
                end else if (a_req) begin
                    grant = 1'b1;
                end else if (b_req) begin
                    grant = 1'b1;
                    sel_b = 1'b1;
                end
                if (grant) begin
                    gnt_nx        = sel_b;
                    last_grant_nx = sel_b;
                    sel_we        = sel_b ? b_we : a_we;
                    mem_addr_nx   = sel_b ? b_addr : a_addr;
                    if (sel_we) begin
                        mem_wdata_nx = sel_b ? b_wdata : a_wdata;
                        mem_r_w_nx   = 1'b1;
                        state_nx     = WR;
                    end else begin
                        state_nx = RD;
                    end
                end
            end
            WR: begin
                state_nx = DONE;
                a_ack_nx = ~gnt;
                b_ack_nx = gnt;
            end
            RD: state_nx = RDWAIT;
            RDWAIT: begin
                state_nx = DONE;
                a_ack_nx = ~gnt;
                b_ack_nx = gnt;
                if (gnt) b_rdata_nx = mem_rdata;
                else     a_rdata_nx = mem_rdata;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            mem_r_w    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            last_grant <= last_grant_nx;
            gnt        <= gnt_nx;
            mem_r_w    <= mem_r_w_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            a_ack      <= a_ack_nx;
            b_ack      <= b_ack_nx;
            a_rdata    <= a_rdata_nx;
            b_rdata    <= b_rdata_nx;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory, an ack
// scoreboard and a memory-write scoreboard.
module tb_mem_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              a_req = 1'b0, a_we = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_wdata = '0;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              b_req = 1'b0, b_we = 1'b0;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_wdata = '0;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              mem_r_w;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [2:0]        dbg_state;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // ack entry: {port(1=B), is_read, rdata}; write entry: {addr, data}
    logic [DATA_W+1:0]        exp_q[$];
    logic [ADDR_W+DATA_W-1:0] wexp_q[$];

    int checks = 0;
    int errors = 0;
    int lat, lat_a, lat_b;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_r_w(mem_r_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // clock / memory model
    always #5 clk = ~clk;

    initial for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;

    always @(posedge clk) begin
        if (mem_r_w) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // driver: call just after a rising edge; returns negedges until ack
    task automatic do_access(input bit port, input bit we, input int addr,
                             input int wdata, input bit keep, output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        if (port) begin
            b_we = we; b_addr = addr[ADDR_W-1:0]; b_wdata = wdata[DATA_W-1:0]; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = addr[ADDR_W-1:0]; a_wdata = wdata[DATA_W-1:0]; a_req = 1'b1;
        end
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            got = port ? b_ack : a_ack;
        end
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout port %0d: no ack after %0d cycles", port, cyc);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            if (port) b_req = 1'b0;
            else      a_req = 1'b0;
        end
    endtask

    function automatic void push_acc(bit port, bit we, int addr, int data);
        exp_q.push_back({port, ~we, we ? 8'h00 : data[DATA_W-1:0]});
        if (we) wexp_q.push_back({addr[ADDR_W-1:0], data[DATA_W-1:0]});
    endfunction

    // monitor: ack scoreboard and memory-write scoreboard
    always @(negedge clk) begin
        logic [DATA_W+1:0]        e;
        logic [ADDR_W+DATA_W-1:0] w;
        if (a_ack && b_ack) begin
            errors++;
            $display("FAIL dual_ack: a_ack=1 b_ack=1 required at most one");
        end else if (a_ack || b_ack) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: port %0d acked, none required", b_ack);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", {31'd0, b_ack}, {31'd0, e[DATA_W+1]});
                if (e[DATA_W]) check("rdata", b_ack ? b_rdata : a_rdata, e[DATA_W-1:0]);
            end
        end
        if (mem_r_w) begin
            if (wexp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, none required", mem_addr, mem_wdata);
            end else begin
                w = wexp_q.pop_front();
                check("mem_write", {mem_addr, mem_wdata}, w);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_a_ack", a_ack, 0);
        check("rst_b_ack", b_ack, 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_b_rdata", b_rdata, 0);
        check("rst_mem_r_w", mem_r_w, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_state", dbg_state, 0);
        @(posedge clk); #1;

        // single write, then read-back from B
        push_acc(0, 1, 3, 8'hA5);
        do_access(0, 1, 3, 8'hA5, 0, lat);
        check("wr_latency", lat, 3);
        push_acc(1, 0, 3, 8'hA5);
        do_access(1, 0, 3, 0, 0, lat);
        check("rd_latency", lat, 4);
        repeat (2) @(negedge clk);
        check("b_rdata_held", b_rdata, 8'hA5);
        check("a_rdata_unchanged", a_rdata, 0);
        @(posedge clk); #1;

        // contention straight after reset: A wins first
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        push_acc(0, 1, 1, 8'h11);
        push_acc(1, 1, 2, 8'h22);
        fork
            do_access(0, 1, 1, 8'h11, 0, lat_a);
            do_access(1, 1, 2, 8'h22, 0, lat_b);
        join
        check("cont_a_latency", lat_a, 3);
        check("cont_b_latency", lat_b, 6);
        push_acc(0, 0, 1, 8'h11);
        do_access(0, 0, 1, 0, 0, lat);
        push_acc(1, 0, 2, 8'h22);
        do_access(1, 0, 2, 0, 0, lat);

        // fairness with both requesters busy; last grant was B
        push_acc(0, 1, 8, 8'h81);  push_acc(1, 1, 12, 8'hC1);
        push_acc(0, 1, 9, 8'h92);  push_acc(1, 1, 13, 8'hD2);
        push_acc(0, 1, 10, 8'hA3); push_acc(1, 1, 14, 8'hE3);
        fork
            begin
                do_access(0, 1, 8, 8'h81, 1, lat_a);
                do_access(0, 1, 9, 8'h92, 1, lat_a);
                do_access(0, 1, 10, 8'hA3, 0, lat_a);
            end
            begin
                do_access(1, 1, 12, 8'hC1, 1, lat_b);
                do_access(1, 1, 13, 8'hD2, 1, lat_b);
                do_access(1, 1, 14, 8'hE3, 0, lat_b);
            end
        join

        // back-to-back on A with req held across the ack
        push_acc(0, 1, 5, 8'h55);
        do_access(0, 1, 5, 8'h55, 1, lat);
        check("b2b_wr_latency", lat, 3);
        push_acc(0, 0, 5, 8'h55);
        do_access(0, 0, 5, 0, 0, lat);
        check("b2b_rd_latency", lat, 4);

        // reset during RDWAIT aborts the read without an ack
        a_we = 1'b0; a_addr = 4'd5; a_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort_in_rdwait", dbg_state, 3);
        rst = 1'b1; a_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_a_ack", a_ack, 0);
        check("abort_a_rdata", a_rdata, 0);
        check("abort_state", dbg_state, 0);
        check("abort_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        push_acc(0, 0, 5, 8'h55);
        do_access(0, 0, 5, 0, 0, lat);
        check("after_abort_latency", lat, 4);

        repeat (5) @(negedge clk);
        check("ack_queue_empty", exp_q.size(), 0);
        check("write_queue_empty", wexp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
